// File: rtl/bus_arbiter_32.sv
// bus_arbiter_32: round-robin arbiter for 32 bus sources with a hold-time limit,
// a one-cycle turnaround between owners and a preempt pulse on forced release.
module bus_arbiter_32 #(
    parameter int HOLD_MAX = 16
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] req,
    input  logic        done,
    output logic [31:0] grant,
    output logic [4:0]  grant_idx,
    output logic        grant_valid,
    output logic        preempt
);
    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    state_t     r_state;
    logic [4:0] r_last;
    logic [7:0] r_hold;
    logic [4:0] w_winner;
    logic       w_release;
    // Scan offsets from far to near so the closest requester after r_last wins.
    always_comb begin
        w_winner = '0;
        for (int k = 31; k >= 0; k--)
            if (req[5'(r_last + 5'd1 + 5'(k))]) w_winner = 5'(r_last + 5'd1 + 5'(k));
    end
    assign w_release = done || !req[grant_idx] || (r_hold == HOLD_LAST);
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state     <= IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            preempt     <= 1'b0;
            r_hold      <= '0;
            r_last      <= 5'd31;
        end else if (r_state == GRANT) begin
            // grant_idx doubles as the owner register while in GRANT.
            if (w_release) begin
                r_state     <= TURN;
                grant       <= '0;
                grant_idx   <= '0;
                grant_valid <= 1'b0;
                r_last      <= grant_idx;
                preempt     <= !done && req[grant_idx];
            end else begin
                r_hold  <= r_hold + 8'd1;
                preempt <= 1'b0;
            end
        end else begin
            preempt <= 1'b0;
            if (|req) begin
                r_state     <= GRANT;
                grant       <= 32'd1 << w_winner;
                grant_idx   <= w_winner;
                grant_valid <= 1'b1;
                r_hold      <= '0;
            end else begin
                r_state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_bus_arbiter_32.sv
// tb_bus_arbiter_32: directed scenarios plus random traffic against a behavioural
// owner/last-index model of the arbiter.
module tb_bus_arbiter_32;
    localparam int HM = 4;
    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] req = '0;
    logic        done = 1'b0;
    logic [31:0] grant;
    logic [4:0]  grant_idx;
    logic        grant_valid;
    logic        preempt;
    int checks = 0;
    int errors = 0;
    int m_owner = -1;
    int m_hold = 0;
    int m_last = 31;
    bit m_pre = 0;
    logic [31:0] prev_grant = '0;

    bus_arbiter_32 #(.HOLD_MAX(HM)) dut (
        .clock(clock), .clear(clear), .req(req), .done(done),
        .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid), .preempt(preempt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: an owner number (-1 = none), a hold age and the last owner.
    task automatic model_update();
        if (clear) begin
            m_owner = -1; m_hold = 0; m_last = 31; m_pre = 0;
        end else if (m_owner >= 0) begin
            if (done || !req[m_owner] || m_hold == HM - 1) begin
                m_pre = !done && req[m_owner];
                m_last = m_owner;
                m_owner = -1;
            end else begin
                m_hold = (m_hold + 1 > HM - 1) ? HM - 1 : m_hold + 1;
                m_pre = 0;
            end
        end else begin
            m_pre = 0;
            for (int k = 1; k <= 32; k++)
                if (m_owner < 0 && req[(m_last + k) % 32]) begin
                    m_owner = (m_last + k) % 32;
                    m_hold = 0;
                end
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        check("grant", grant, m_owner >= 0 ? 32'd1 << m_owner : 32'd0);
        check("grant_idx", 32'(grant_idx), m_owner >= 0 ? 32'(m_owner) : 32'd0);
        check("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
        check("preempt", 32'(preempt), 32'(m_pre));
        check("onehot", 32'($onehot0(grant)), 32'd1);
        check("idx_consistent", 32'(grant[grant_idx]), 32'(grant_valid));
        check("back_to_back", 32'(prev_grant != 0 && grant != 0 && prev_grant != grant), 32'd0);
        prev_grant = grant;
    endtask

    task automatic do_reset();
        clear = 1'b1; req = '0; done = 1'b0;
        step();
        check("reset_grant", grant, 32'd0);
        check("reset_idx", 32'(grant_idx), 32'd0);
        check("reset_preempt", 32'(preempt), 32'd0);
        clear = 1'b0;
    endtask

    initial begin
        int seq[5] = '{0, 2, 31, 0, 2};
        // basic grant, done on third grant cycle, sole requester re-granted
        do_reset();
        req = 32'h10;
        step();
        check("t1_grant", grant, 32'h10);
        check("t1_idx", 32'(grant_idx), 32'd4);
        step();
        step();
        done = 1'b1;
        step();
        check("t1_turn", grant, 32'd0);
        done = 1'b0;
        step();
        check("t1_regrant", grant, 32'h10);
        // round robin with wrap
        do_reset();
        req = 32'h8000_0005;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_idx", 32'(grant_idx), 32'(seq[i]));
            check("t2_valid", 32'(grant_valid), 32'd1);
            done = 1'b1;
            step();
            check("t2_gap", grant, 32'd0);
            done = 1'b0;
        end
        // hold expiry preemption
        do_reset();
        req = 32'h300;
        for (int i = 0; i < HM; i++) begin
            step();
            check("t3_hold", 32'(grant_idx), 32'd8);
            check("t3_nopre", 32'(preempt), 32'd0);
        end
        step();
        check("t3_turn", grant, 32'd0);
        check("t3_preempt", 32'(preempt), 32'd1);
        step();
        check("t3_next", 32'(grant_idx), 32'd9);
        check("t3_preclr", 32'(preempt), 32'd0);
        // owner drops its request
        do_reset();
        req = 32'h20;
        step();
        check("t4_grant", 32'(grant_idx), 32'd5);
        req = 32'h0;
        step();
        check("t4_turn", grant, 32'd0);
        check("t4_nopre", 32'(preempt), 32'd0);
        req = 32'h21;
        step();
        check("t4_next", 32'(grant_idx), 32'd0);
        // clear in the middle of a grant
        do_reset();
        req = 32'h1000;
        step();
        check("t5_grant", 32'(grant_idx), 32'd12);
        clear = 1'b1;
        step();
        check("t5_cleared", grant, 32'd0);
        check("t5_valid", 32'(grant_valid), 32'd0);
        clear = 1'b0;
        step();
        check("t5_regrant", 32'(grant_idx), 32'd12);
        // random traffic
        for (int i = 0; i < 10000; i++) begin
            req = $urandom() & $urandom() & $urandom();
            if ($urandom_range(0, 7) == 0) req = '0;
            done = ($urandom_range(0, 3) == 0);
            clear = ($urandom_range(0, 99) == 0);
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_arbiter_32.md
BUS_ARBITER_32 -- requirements
Module: bus_arbiter_32

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 16, meaning the maximum number of consecutive cycles one requester may own the bus (legal range 2..255).
REQ-002 Port clock, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port clear, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port req, input, 32 bits: one request bit per bus source; bit i is source i.
REQ-005 Port done, input, 1 bit: the current owner is finished; sampled only in GRANT.
REQ-006 Port grant, output, 32 bits: one-hot bus-drive select to the sources; all-zero when no owner.
REQ-007 Port grant_idx, output, 5 bits: binary index of the set grant bit; 0 when grant is all-zero.
REQ-008 Port grant_valid, output, 1 bit: high exactly when grant is non-zero.
REQ-009 Port preempt, output, 1 bit: one-cycle pulse when an owner is forcibly released by HOLD_MAX expiry.

Function
REQ-010 The block SHALL implement three states: IDLE, GRANT and TURN (one bus-turnaround cycle).
REQ-011 All outputs SHALL be registered; no combinational path from req or done to any output.
REQ-012 Arbitration SHALL be round-robin: the search starts at (last_idx + 1) mod 32, ascending, wrapping 31 -> 0; the first set req bit wins.
REQ-013 IDLE: if req != 0, the SHALL go to GRANT; in the same edge grant = one-hot(winner), grant_idx = winner, grant_valid = 1, owner = winner, hold_cnt = 0.
REQ-014 IDLE: if req == 0, the block SHALL stay in IDLE with all outputs zero.
REQ-015 Latency: grant SHALL be visible in the first cycle after the cycle in which req was sampled non-zero in IDLE or TURN.
REQ-016 GRANT: hold_cnt SHALL increment by 1 each cycle, saturating at HOLD_MAX-1.
REQ-017 GRANT release condition: done == 1, or req[owner] == 0, or hold_cnt == HOLD_MAX-1.
REQ-018 On release the block SHALL go to TURN, clear grant/grant_idx/grant_valid, and set last_idx = owner.
REQ-019 preempt SHALL pulse high in the TURN cycle only when the release was caused solely by hold_cnt expiry (done == 0 and req[owner] == 1).
REQ-020 When done and expiry coincide, the release SHALL count as done, and preempt SHALL stay 0.
REQ-021 TURN SHALL last exactly one cycle with grant == 0, guaranteeing no two sources ever drive the bus in consecutive cycles.
REQ-022 From TURN the block SHALL arbitrate exactly as in IDLE (REQ-013/014): go to GRANT with the new winner, or to IDLE if req == 0.
REQ-023 The block SHALL never change owner while in GRANT; req changes from other sources in GRANT SHALL be ignored.
REQ-024 Only a sole requester SHALL be re-granted to the same source after its release, and only after the TURN cycle.
REQ-025 grant SHALL be one-hot or zero in every cycle, and grant[grant_idx] == grant_valid at all times.

Reset
REQ-026 When clear == 1 at a rising edge: state = IDLE, grant = 0, grant_idx = 0, grant_valid = 0, preempt = 0, hold_cnt = 0, last_idx = 31 (so the first search starts at source 0).
REQ-027 clear SHALL override all other inputs, including mid-GRANT; the owner is dropped immediately without a TURN cycle or preempt pulse.
REQ-028 The first cycle after clear deasserts SHALL behave as IDLE.

Verification
REQ-029 Test 1 (basic grant): after reset, req = 0x0000_0010 for 1 cycle, then held; done pulsed at grant cycle 3 -> grant = 0x10 and grant_idx = 4 one cycle after req; then grant = 0 (TURN) after done; then re-grant to 4 the following cycle.
REQ-030 Test 2 (round-robin): req = 0x8000_0005 held, with done pulsed 1 cycle after each grant -> grant_idx sequence 0, 2, 31, 0, 2, with a zero-grant cycle between each.
REQ-031 Test 3 (preempt): HOLD_MAX = 4, req = 0x0000_0300 held, done = 0 -> source 8 is granted for 4 cycles; then TURN with preempt = 1 for 1 cycle; then source 9 is granted.
REQ-032 Test 4 (owner drops request): source 5 granted, then req[5] cleared -> TURN the next cycle, preempt = 0, last_idx = 5; with req = 0x21 the next grant is source 0.
REQ-033 Test 5 (reset mid-operation): clear asserted during GRANT of source 12 -> next cycle all outputs 0; with req = 0x1000 after clear deasserts, source 12 is granted again from a search start of 0.
REQ-034 Test 6 (invariant): 10,000 cycles of random req/done with random clear -> grant is always one-hot or zero, grant_idx is consistent with grant, and no cycle grants two different sources back-to-back.
